// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, constants and parity helper
// Used by the host transmitter and the device-to-host receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_WAIT_IDLE
  } ps2_state_e;

  // Cycles the host holds data low with clk inhibited before releasing clk.
  localparam int REQ_CYC   = 16;
  // Bits clocked out by the device after the start bit: d0..d7, parity, stop.
  localparam int FRAME_LEN = 10;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - pad synchronizer and clock falling-edge strobe
// Ports: clk, rst (async, active-high); clk_pad, data_pad raw pad inputs;
//        clk_sync, data_sync synchronized levels; fall one-cycle strobe per
//        falling edge of the synchronized clock.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_pad,
  input  logic data_pad,
  output logic clk_sync,
  output logic data_sync,
  output logic fall
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       clk_prev;

  // Reset to 1: an idle PS/2 bus floats high, so no false edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_ff   <= 2'b11;
      data_ff  <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], clk_pad};
      data_ff  <= {data_ff[0], data_pad};
      clk_prev <= clk_ff[1];
    end
  end

  assign clk_sync  = clk_ff[1];
  assign data_sync = data_ff[1];
  assign fall      = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
// Ports: clk, rst (async, active-high); tx_data/tx_valid/tx_ready request
//        handshake; tx_done pulse with tx_err (NACK or timeout); busy;
//        ps2_clk_in/ps2_data_in raw pads; ps2_*_out constant 0;
//        ps2_*_oe 1 = pull line low.
// Macro PS2_TX_WATCHDOG_EN adds a TIMEOUT_MS watchdog over SHIFT/WAIT_IDLE.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 25_000_000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_MS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_out,
  output logic       ps2_data_out,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INHIBIT_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
  localparam int CNT_MAX     = (INHIBIT_CYC > REQ_CYC) ? INHIBIT_CYC : REQ_CYC;
  localparam int CNT_W       = $clog2(CNT_MAX + 1);

  if (INHIBIT_CYC < 1 || TIMEOUT_MS < 1) begin : g_param_check
    $error("ps2_host_tx: INHIBIT_US and TIMEOUT_MS must be at least 1");
  end

  ps2_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  // Start bit in [0], then the FRAME_LEN bits the device clocks out.
  logic [FRAME_LEN:0]   frame_q, frame_d;
  logic                 nack_q, nack_d;
  logic                 clk_oe_q, clk_oe_d;
  logic                 data_oe_q, data_oe_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 clk_sync, data_sync, fall;
  logic                 wd_expired;

  ps2_line_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .clk_pad   (ps2_clk_in),
    .data_pad  (ps2_data_in),
    .clk_sync  (clk_sync),
    .data_sync (data_sync),
    .fall      (fall)
  );

`ifdef PS2_TX_WATCHDOG_EN
  localparam int TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int WD_W        = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_q;
  logic            wd_run;

  // Cleared while the host still owns the clock, so it starts at the release.
  assign wd_run = (state_q == ST_SHIFT) || (state_q == ST_WAIT_IDLE && !done_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          wd_q <= '0;
    else if (wd_run)  wd_q <= wd_q + WD_W'(1);
    else              wd_q <= '0;
  end

  assign wd_expired = wd_run && (wd_q == WD_W'(TIMEOUT_CYC - 1));
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      frame_q   <= '1;
      nack_q    <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      nack_q    <= nack_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    nack_d    = nack_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          frame_d   = {1'b1, odd_parity(tx_data), tx_data, 1'b0};
          cnt_d     = '0;
          bit_cnt_d = '0;
          nack_d    = 1'b0;
          state_d   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYC - 1)) begin
          cnt_d   = '0;
          state_d = ST_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REQ: begin
        if (cnt_q == CNT_W'(REQ_CYC - 1)) begin
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (wd_expired) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = ST_WAIT_IDLE;
        end else if (fall) begin
          frame_d   = {1'b1, frame_q[FRAME_LEN:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          // The fall after the stop bit is the device's acknowledge slot.
          if (bit_cnt_q == 4'(FRAME_LEN)) begin
            nack_d  = data_sync;
            state_d = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        // Stay one cycle past the done pulse so tx_ready rises after it.
        if (done_q) begin
          state_d = ST_IDLE;
        end else if (wd_expired) begin
          done_d = 1'b1;
          err_d  = 1'b1;
        end else if (clk_sync && data_sync) begin
          done_d = 1'b1;
          err_d  = nack_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    clk_oe_d  = (state_d == ST_INHIBIT) || (state_d == ST_REQ);
    data_oe_d = ((state_d == ST_REQ) || (state_d == ST_SHIFT)) ? ~frame_d[0] : 1'b0;
  end

  assign tx_ready     = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign tx_done      = done_q;
  assign tx_err       = err_q;
  assign ps2_clk_oe   = clk_oe_q;
  assign ps2_data_oe  = data_oe_q;
  assign ps2_clk_out  = 1'b0;
  assign ps2_data_out = 1'b0;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

  localparam int CLK_HZ      = 5_000_000;
  localparam int INHIBIT_US  = 100;
  localparam int TIMEOUT_MS  = 1;
  localparam int INHIBIT_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
  localparam int TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int REQ_CYC     = 16;
  localparam int HALF        = CLK_HZ / 25_000;        // 12.5 kHz device clock
  localparam int US50        = CLK_HZ / 1_000_000 * 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err, busy;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_out, ps2_data_out;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] data;
    logic       nack;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Open-drain bus: either side pulling low wins.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .CLK_HZ     (CLK_HZ),
    .INHIBIT_US (INHIBIT_US),
    .TIMEOUT_MS (TIMEOUT_MS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_done      (tx_done),
    .tx_err       (tx_err),
    .busy         (busy),
    .ps2_clk_in   (ps2_clk_in),
    .ps2_data_in  (ps2_data_in),
    .ps2_clk_out  (ps2_clk_out),
    .ps2_data_out (ps2_data_out),
    .ps2_clk_oe   (ps2_clk_oe),
    .ps2_data_oe  (ps2_data_oe)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Scoreboard: every tx_done must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && tx_done) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_done", 32'(tx_done), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("tx_err", 32'(tx_err), 32'(mon_e.nack));
        check_eq("done_lines_released", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        check_eq("ready_during_done", 32'(tx_ready), 0);
      end
    end
  end

  task automatic push_exp(input logic [7:0] d, input logic nack);
    exp_t e;
    e.data = d;
    e.nack = nack;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] d, input logic nack);
    check_eq("ready_before_send", 32'(tx_ready), 1);
    tx_data  = d;
    tx_valid = 1'b1;
    push_exp(d, nack);
    @(negedge clk);
    tx_valid = 1'b0;
    check_eq("accept_clk_oe", 32'(ps2_clk_oe), 1);
    check_eq("busy_after_accept", 32'(busy), 1);
  endtask

  task automatic wait_clk_release();
    int n;
    n = 0;
    while (ps2_clk_oe && n < INHIBIT_CYC + REQ_CYC + 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("clk_release", 32'(ps2_clk_oe), 0);
  endtask

  // Device side of one frame: measure inhibit/request, clock 10 bits out,
  // acknowledge (or not), optionally hold data low, then time tx_done.
  task automatic dev_frame(input logic [7:0] d, input logic nack, input int hold);
    int n, hi, req, seen;
    logic [9:0] bits, want;
    n = 0;
    while (!ps2_clk_oe && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("inhibit_start", 32'(ps2_clk_oe), 1);
    hi = 0;
    req = 0;
    while (ps2_clk_oe && hi < INHIBIT_CYC + REQ_CYC + 50) begin
      if (ps2_data_oe) req++;
      hi++;
      @(negedge clk);
    end
    check_eq("clk_inhibit_len", hi, INHIBIT_CYC + REQ_CYC);
    check_eq("req_len", req, REQ_CYC);
    check_eq("start_bit_held", 32'(ps2_data_in), 0);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      @(negedge clk);
      bits[i] = ps2_data_in;
      repeat (HALF - 1) @(negedge clk);
    end
    want = {1'b1, ~^d, d};
    check_eq("frame_bits", 32'(bits), 32'(want));
    dev_data = nack;
    repeat (5) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    seen = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (tx_done) seen++;
    end
    if (hold > 0) check_eq("no_done_while_held", seen, 0);
    dev_data = 1'b1;
    n = 0;
    while (!tx_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_latency", n, 3);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(tx_ready), 1);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(tx_done), 0);
    check_eq("rst_err", 32'(tx_err), 0);
    check_eq("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 0);
    check_eq("rst_out", 32'({ps2_clk_out, ps2_data_out}), 0);
    rst = 1'b0;
    @(negedge clk);

    // 0xF4 with ACK
    send(8'hF4, 1'b0);
    dev_frame(8'hF4, 1'b0, 0);
    repeat (10) @(negedge clk);

    // 0xFF with NACK; parity bit must be 1
    send(8'hFF, 1'b1);
    dev_frame(8'hFF, 1'b1, 0);
    repeat (10) @(negedge clk);

    // 0x00, a stray request mid-frame, then a held request taken back-to-back
    send(8'h00, 1'b0);
    fork
      dev_frame(8'h00, 1'b0, 0);
      begin
        repeat (3000) @(negedge clk);
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        check_eq("ready_mid_frame", 32'(tx_ready), 0);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (500) @(negedge clk);
        tx_valid = 1'b1;
        push_exp(8'hAA, 1'b0);
      end
    join
    @(negedge clk);
    check_eq("ready_after_done", 32'(tx_ready), 1);
    check_eq("idle_clk_oe", 32'(ps2_clk_oe), 0);
    @(negedge clk);
    tx_valid = 1'b0;
    check_eq("b2b_accept", 32'(ps2_clk_oe), 1);
    dev_frame(8'hAA, 1'b0, 0);
    repeat (10) @(negedge clk);

    // Reset after fall 5 while d4 = 0 holds the data line low
    send(8'h0F, 1'b0);
    wait_clk_release();
    repeat (20) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    dev_clk = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("pre_rst_data_oe", 32'(ps2_data_oe), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_now_data_oe", 32'(ps2_data_oe), 0);
    check_eq("rst_now_clk_oe", 32'(ps2_clk_oe), 0);
    check_eq("rst_now_ready", 32'(tx_ready), 1);
    exp_q.delete();
    dev_clk = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3000) @(negedge clk);
    check_eq("post_rst_idle", 32'(busy), 0);

    // 0x3C with ACK, device holds data low 50 us afterwards
    send(8'h3C, 1'b0);
    dev_frame(8'h3C, 1'b0, US50);
    repeat (10) @(negedge clk);

    // Device never clocks
`ifdef PS2_TX_WATCHDOG_EN
    send(8'h12, 1'b1);
    wait_clk_release();
    n = 0;
    while (!tx_done && n < TIMEOUT_CYC + 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("wd_latency", n, TIMEOUT_CYC);
    @(negedge clk);
    check_eq("wd_ready", 32'(tx_ready), 1);
`else
    send(8'h12, 1'b0);
    wait_clk_release();
    repeat (2 * TIMEOUT_CYC) @(negedge clk);
    check_eq("no_wd_busy", 32'(busy), 1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("no_wd_rst_ready", 32'(tx_ready), 1);
`endif

    check_eq("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    bad++;
    $display("FAIL global_timeout: got=running want=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
